// File: rtl/mem_access_unit.sv
// Load/store unit between the pipeline and a word-wide handshaked memory.
// Supports LW/SW/LB/SB, flags misaligned word accesses and memory timeouts.
module mem_access_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic        isByte,
    input  logic [31:0] address,
    input  logic [31:0] writeData,
    output logic        stall,
    output logic [31:0] readData,
    output logic        loadValid,
    output logic        alignErr,
    output logic        busErr,
    output logic        memReq,
    output logic        memWe,
    output logic [29:0] memAddr,
    output logic [31:0] memWData,
    output logic [3:0]  memBe,
    input  logic        memAck,
    input  logic [31:0] memRData
);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t      r_state;
    state_t      w_next;
    logic [7:0]  r_cnt;
    logic        r_we;
    logic        r_isload;
    logic        r_isbyte;
    logic [1:0]  r_lane;
    logic [29:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_be;
    logic [31:0] r_rdata;
    logic        r_buserr;

    logic        w_access;
    logic        w_aligned;
    logic        w_start;
    logic        w_timeout;

    function automatic logic [31:0] lane_sext(input logic [31:0] data, input logic [1:0] lane);
        logic [7:0] b;
        case (lane)
            2'd0:    b = data[7:0];
            2'd1:    b = data[15:8];
            2'd2:    b = data[23:16];
            default: b = data[31:24];
        endcase
        return {{24{b[7]}}, b};
    endfunction

    assign w_access  = memRead | memWrite;
    assign w_aligned = isByte | (address[1:0] == 2'b00);
    assign w_start   = (r_state == IDLE) & w_access & w_aligned;
    assign w_timeout = (r_cnt == TO_LAST);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_start) w_next = WAIT;
            WAIT:    if (memAck || w_timeout) w_next = DONE;
            default: w_next = IDLE;
        endcase
    end

    // Request-side outputs are gated with rst_n so reset masks them even while decode inputs are live.
    assign stall     = rst_n & (w_start | (r_state == WAIT));
    assign alignErr  = rst_n & (r_state == IDLE) & w_access & ~w_aligned;
    assign memReq    = (r_state == WAIT);
    assign loadValid = (r_state == DONE) & r_isload;
    assign busErr    = (r_state == DONE) & r_buserr;
    assign readData  = r_rdata;
    assign memWe     = r_we;
    assign memAddr   = r_addr;
    assign memWData  = r_wdata;
    assign memBe     = r_be;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_we     <= 1'b0;
            r_isload <= 1'b0;
            r_isbyte <= 1'b0;
            r_lane   <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_be     <= '0;
            r_rdata  <= '0;
            r_buserr <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: if (w_start) begin
                    r_we     <= memWrite;
                    r_isload <= ~memWrite;
                    r_isbyte <= isByte;
                    r_lane   <= address[1:0];
                    r_addr   <= address[31:2];
                    r_wdata  <= (memWrite && isByte) ? {4{writeData[7:0]}} : writeData;
                    r_be     <= (memWrite && isByte) ? (4'b0001 << address[1:0]) : 4'b1111;
                    r_cnt    <= '0;
                    r_buserr <= 1'b0;
                end
                WAIT: begin
                    // An ack on the final allowed cycle still counts as success.
                    if (memAck) begin
                        r_rdata  <= r_isbyte ? lane_sext(memRData, r_lane) : memRData;
                        r_buserr <= 1'b0;
                    end else if (w_timeout) begin
                        r_rdata  <= '0;
                        r_buserr <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
